// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command responder.
// Opcodes, response codes and the FSM state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_DATA = 8'h44;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_EXEC     = 3'd3,
    ST_TX_WAIT  = 3'd4
  } cmd_state_t;

  function automatic logic is_opcode(
    input logic [7:0] b
  );
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// Register file behind the command responder.
// One write port, one combinational read port, flat view.
module uart_cmd_regfile
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS = 16,
  localparam int AW = (NUM_REGS > 1) ?
                      $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [8*NUM_REGS-1:0] regs
);

  logic [7:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs[8*k +: 8] = mem[k];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level read/write command responder behind the UART.
// Parses W/R frames, drives a paced response stream.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int TX_GAP   = 1100,
  parameter int TIMEOUT  = 100000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            rdata,
  input  logic                  rdata_valid,
  output logic [7:0]            tdata,
  output logic                  tdata_req,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  wr_pulse,
  output logic [7:0]            wr_addr,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int AW = (NUM_REGS > 1) ?
                      $clog2(NUM_REGS) : 1;
  localparam int GW = $clog2(TX_GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(TX_GAP - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT - 1);

  cmd_state_t state;

  logic [7:0]    op_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    pend_byte;
  logic          bad_q;
  logic          pend_q;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;

  logic       in_rx;
  logic       in_exec;
  logic       in_txw;
  logic       gap_hit;
  logic       to_hit;
  logic       err_inc;
  logic       rf_we;
  logic [7:0] rf_rdata;

  function automatic logic addr_ok(
    input logic [7:0] a
  );
    return {1'b0, a} < 9'(NUM_REGS);
  endfunction

  assign in_rx   = (state == ST_GET_ADDR) ||
                   (state == ST_GET_DATA);
  assign in_exec = (state == ST_EXEC);
  assign in_txw  = (state == ST_TX_WAIT);
  assign gap_hit = (gap_cnt == GAP_LAST);
  assign to_hit  = (to_cnt == TO_LAST);
  assign busy    = (state != ST_IDLE);
  assign rf_we   = in_exec && !bad_q &&
                   (op_q == OP_WR);

  uart_cmd_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .rstn  (rstn),
    .we    (rf_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (data_q),
    .rdata (rf_rdata),
    .regs  (regs)
  );

  // One increment per cycle even if a drop coincides
  // with an error or a timeout.
  always_comb begin
    err_inc = 1'b0;
    unique case (1'b1)
      in_exec: err_inc = bad_q || rdata_valid;
      in_txw:  err_inc = rdata_valid;
      in_rx:   err_inc = !rdata_valid && to_hit;
      default: err_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (err_inc &&
                 (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      pend_byte <= '0;
      bad_q     <= 1'b0;
      pend_q    <= 1'b0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      tdata     <= '0;
      tdata_req <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
    end else begin
      tdata_req <= 1'b0;
      wr_pulse  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rdata_valid) begin
            op_q   <= rdata;
            to_cnt <= '0;
            if (is_opcode(rdata)) begin
              bad_q <= 1'b0;
              state <= ST_GET_ADDR;
            end else begin
              bad_q <= 1'b1;
              state <= ST_EXEC;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rdata_valid) begin
            addr_q <= rdata;
            to_cnt <= '0;
            if (op_q == OP_RD) begin
              bad_q <= !addr_ok(rdata);
              state <= ST_EXEC;
            end else begin
              state <= ST_GET_DATA;
            end
          end else if (to_hit) begin
            to_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_GET_DATA: begin
          // A bad-address write still eats its data byte.
          if (rdata_valid) begin
            data_q <= rdata;
            to_cnt <= '0;
            bad_q  <= !addr_ok(addr_q);
            state  <= ST_EXEC;
          end else if (to_hit) begin
            to_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_EXEC: begin
          tdata_req <= 1'b1;
          gap_cnt   <= '0;
          state     <= ST_TX_WAIT;
          pend_q    <= 1'b0;
          if (bad_q) begin
            tdata <= RSP_ERR;
          end else if (op_q == OP_WR) begin
            tdata    <= RSP_OK;
            wr_pulse <= 1'b1;
            wr_addr  <= addr_q;
          end else begin
            tdata     <= RSP_DATA;
            pend_q    <= 1'b1;
            pend_byte <= rf_rdata;
          end
        end
        ST_TX_WAIT: begin
          if (gap_hit) begin
            gap_cnt <= '0;
            if (pend_q) begin
              tdata     <= pend_byte;
              tdata_req <= 1'b1;
              pend_q    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
